// File: rtl/sys_ctrl_rf_master_if.sv
// sys_ctrl_rf_master_if: UART RX/TX and register-file bus seen by the command controller
interface sys_ctrl_rf_master_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
);
  logic [WIDTH-1:0] RX_P_DATA;
  logic             RX_D_VLD;
  logic [WIDTH-1:0] RdData;
  logic             RdData_VLD;
  logic             TX_Busy;
  logic             WrEn;
  logic             RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] TX_P_DATA;
  logic             TX_D_VLD;
  logic             CMD_ERR;
  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_VLD, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
  );
endinterface

// File: rtl/sys_ctrl_rf_master.sv
// sys_ctrl_rf_master: decodes UART write/read command frames into register-file accesses
module sys_ctrl_rf_master #(
  parameter int         WIDTH   = 8,
  parameter int         ADDR    = 4,
  parameter logic [7:0] WR_CMD  = 8'hAA,
  parameter logic [7:0] RD_CMD  = 8'hBB,
  parameter int         TIMEOUT = 8
) (
  input logic                   CLK,
  input logic                   RST,
  sys_ctrl_rf_master_if.master  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.WrEn      <= 1'b0;
      bus.RdEn      <= 1'b0;
      bus.Address   <= '0;
      bus.WrData    <= '0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
      bus.CMD_ERR   <= 1'b0;
    end else begin
      bus.WrEn     <= 1'b0;
      bus.RdEn     <= 1'b0;
      bus.TX_D_VLD <= 1'b0;
      bus.CMD_ERR  <= 1'b0;
      case (state)
        IDLE: if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WIDTH'(WR_CMD)) state <= WR_ADDR;
          else if (bus.RX_P_DATA == WIDTH'(RD_CMD)) state <= RD_ADDR;
          else bus.CMD_ERR <= 1'b1;
        end
        WR_ADDR: if (bus.RX_D_VLD) begin
          bus.Address <= bus.RX_P_DATA[ADDR-1:0];
          state       <= WR_DATA;
        end
        WR_DATA: if (bus.RX_D_VLD) begin
          bus.WrData <= bus.RX_P_DATA;
          bus.WrEn   <= 1'b1;
          state      <= IDLE;
        end
        RD_ADDR: if (bus.RX_D_VLD) begin
          bus.Address <= bus.RX_P_DATA[ADDR-1:0];
          bus.RdEn    <= 1'b1;
          cnt         <= '0;
          state       <= RD_WAIT;
        end
        RD_WAIT: begin
          // a stray RX byte is dropped but must not lose a read response arriving alongside it
          bus.CMD_ERR <= bus.RX_D_VLD;
          if (bus.RdData_VLD) begin
            // the capture edge doubles as the send edge when TX is free: 3-cycle read turnaround
            bus.TX_P_DATA <= bus.RdData;
            bus.TX_D_VLD  <= !bus.TX_Busy;
            cnt           <= '0;
            state         <= bus.TX_Busy ? TX_SEND : IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.CMD_ERR <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else cnt <= cnt + CW'(1);
        end
        TX_SEND: begin
          bus.CMD_ERR <= bus.RX_D_VLD;
          if (!bus.TX_Busy) begin
            bus.TX_D_VLD <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_rf_master.sv
// tb_sys_ctrl_rf_master: directed frames plus random traffic checked every cycle against a frame-level model
module tb_sys_ctrl_rf_master;
  localparam int WIDTH = 8, ADDR = 4, TIMEOUT = 8;
  localparam logic [7:0] WR_CMD = 8'hAA, RD_CMD = 8'hBB;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_chk = 0, n_fail = 0;
  sys_ctrl_rf_master_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus();
  sys_ctrl_rf_master #(.WIDTH(WIDTH), .ADDR(ADDR), .WR_CMD(WR_CMD), .RD_CMD(RD_CMD), .TIMEOUT(TIMEOUT))
    dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // register file stand-in: answers a read rf_lat cycles after seeing RdEn (0 = never answers)
  logic [7:0] rf_mem [16];
  int rf_lat = 1;
  int cd = 0;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cd = 0;
      for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 37 + 11);
      bus.RdData_VLD <= 1'b0;
      bus.RdData     <= 8'h00;
    end else begin
      bus.RdData_VLD <= 1'b0;
      if (bus.WrEn) rf_mem[bus.Address] = bus.WrData;
      if (bus.RdEn) cd = rf_lat;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.RdData_VLD <= 1'b1;
          bus.RdData     <= rf_mem[bus.Address];
        end
      end
    end
  end

  // frame-level model: bytes collected in a queue, read wait and pending transmit as flags
  logic [7:0] q[$];
  logic [7:0] b;
  bit m_wait, m_send;
  int m_cnt;
  logic e_wren, e_rden, e_txv, e_err;
  logic [3:0] e_addr;
  logic [7:0] e_wdata, e_txd;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q.delete();
      m_wait = 0; m_send = 0; m_cnt = 0;
      e_wren = 0; e_rden = 0; e_txv = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_txd = 0;
    end else begin
      e_wren = 0; e_rden = 0; e_txv = 0; e_err = 0;
      if (m_wait) begin
        e_err = bus.RX_D_VLD;
        m_cnt++;
        if (bus.RdData_VLD) begin
          e_txd = bus.RdData;
          m_wait = 0;
          if (bus.TX_Busy) m_send = 1; else e_txv = 1;
        end else if (m_cnt == TIMEOUT) begin
          e_err = 1;
          m_wait = 0;
        end
      end else if (m_send) begin
        e_err = bus.RX_D_VLD;
        if (!bus.TX_Busy) begin e_txv = 1; m_send = 0; end
      end else if (bus.RX_D_VLD) begin
        b = bus.RX_P_DATA;
        if (q.size() == 0) begin
          if (b == WR_CMD || b == RD_CMD) q.push_back(b); else e_err = 1;
        end else if (q.size() == 1) begin
          e_addr = b[3:0];
          if (q[0] == RD_CMD) begin
            e_rden = 1; m_wait = 1; m_cnt = 0; q.delete();
          end else q.push_back(b);
        end else begin
          e_wdata = b; e_wren = 1; q.delete();
        end
      end
    end
  end

  always @(negedge CLK) if (!RST) begin
    chk("WrEn", bus.WrEn, e_wren);
    chk("RdEn", bus.RdEn, e_rden);
    chk("Address", bus.Address, e_addr);
    chk("WrData", bus.WrData, e_wdata);
    chk("TX_P_DATA", bus.TX_P_DATA, e_txd);
    chk("TX_D_VLD", bus.TX_D_VLD, e_txv);
    chk("CMD_ERR", bus.CMD_ERR, e_err);
    chk("WrEn_RdEn_excl", bus.WrEn & bus.RdEn, 0);
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask
  task automatic send(input logic [7:0] v);
    bus.RX_P_DATA = v; bus.RX_D_VLD = 1'b1;
    tick();
    bus.RX_D_VLD = 1'b0;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_WrEn"}, bus.WrEn, 0);
    chk({tag, "_RdEn"}, bus.RdEn, 0);
    chk({tag, "_Address"}, bus.Address, 0);
    chk({tag, "_WrData"}, bus.WrData, 0);
    chk({tag, "_TX_P_DATA"}, bus.TX_P_DATA, 0);
    chk({tag, "_TX_D_VLD"}, bus.TX_D_VLD, 0);
    chk({tag, "_CMD_ERR"}, bus.CMD_ERR, 0);
  endtask

  initial begin
    int r;
    bus.RX_P_DATA = 8'h00; bus.RX_D_VLD = 1'b0; bus.TX_Busy = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk_zero("reset");
    RST = 1'b0;
    tick();
    // reset in the middle of a write frame
    send(WR_CMD); send(8'h05);
    chk("t1_addr_before_rst", bus.Address, 4'h5);
    #2 RST = 1'b1;
    #1 chk_zero("t1_async_rst");
    tick();
    RST = 1'b0;
    send(RD_CMD); send(8'h05);
    chk("t1_rden", bus.RdEn, 1);
    chk("t1_addr", bus.Address, 4'h5);
    chk("t1_wren", bus.WrEn, 0);
    repeat (4) tick();
    // write AA,03,5C
    send(WR_CMD); send(8'h03); send(8'h5C);
    chk("t2_wren", bus.WrEn, 1);
    chk("t2_addr", bus.Address, 4'h3);
    chk("t2_wdata", bus.WrData, 8'h5C);
    chk("t2_rden", bus.RdEn, 0);
    tick();
    chk("t2_wren_drop", bus.WrEn, 0);
    // read BB,03
    send(RD_CMD); send(8'h03);
    chk("t3_rden", bus.RdEn, 1);
    chk("t3_addr", bus.Address, 4'h3);
    tick();
    chk("t3_rden_drop", bus.RdEn, 0);
    chk("t3_txv_early", bus.TX_D_VLD, 0);
    tick();
    chk("t3_txv", bus.TX_D_VLD, 1);
    chk("t3_txd", bus.TX_P_DATA, 8'h5C);
    tick();
    chk("t3_txv_drop", bus.TX_D_VLD, 0);
    // read with transmitter busy
    bus.TX_Busy = 1'b1;
    send(RD_CMD); send(8'h03);
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("t4_txv_busy", bus.TX_D_VLD, 0);
      chk("t4_txd_hold", bus.TX_P_DATA, 8'h5C);
      tick();
    end
    bus.TX_Busy = 1'b0;
    chk("t4_txv_pre", bus.TX_D_VLD, 0);
    tick();
    chk("t4_txv", bus.TX_D_VLD, 1);
    chk("t4_txd", bus.TX_P_DATA, 8'h5C);
    tick();
    chk("t4_txv_drop", bus.TX_D_VLD, 0);
    // unknown command then a good write
    send(8'h12);
    chk("t5_err", bus.CMD_ERR, 1);
    chk("t5_wren", bus.WrEn, 0);
    chk("t5_rden", bus.RdEn, 0);
    tick();
    chk("t5_err_drop", bus.CMD_ERR, 0);
    send(WR_CMD); send(8'h01); send(8'hFF);
    chk("t5_wren2", bus.WrEn, 1);
    chk("t5_addr2", bus.Address, 4'h1);
    chk("t5_wdata2", bus.WrData, 8'hFF);
    // read timeout with upper address bits set
    rf_lat = 0;
    send(RD_CMD); send(8'hF7);
    chk("t6_rden", bus.RdEn, 1);
    chk("t6_addr", bus.Address, 4'h7);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("t6_err_early", bus.CMD_ERR, 0);
      chk("t6_txv", bus.TX_D_VLD, 0);
    end
    tick();
    chk("t6_err", bus.CMD_ERR, 1);
    chk("t6_txv_end", bus.TX_D_VLD, 0);
    tick();
    chk("t6_err_drop", bus.CMD_ERR, 0);
    rf_lat = 1;
    // random traffic, busy toggling, response latency changes and occasional async resets
    repeat (3000) begin
      bus.RX_D_VLD = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 3);
      bus.RX_P_DATA = (r == 0) ? WR_CMD : (r == 1) ? RD_CMD : 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.TX_Busy = ~bus.TX_Busy;
      if ($urandom_range(0, 49) == 0) rf_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 399) == 0) begin
        #1 RST = 1'b1;
        #1 RST = 1'b0;
      end
      tick();
    end
    bus.RX_D_VLD = 1'b0;
    bus.TX_Busy = 1'b0;
    repeat (TIMEOUT + 4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
